// File: rtl/mure_uop_builder.sv
// Commit-port uop builder: classifies committed instructions and merges STD runs into uop records.
// Optional compressed-instruction decode is enabled by defining MURE_COMPRESSED_EN.

package mure_pkg;
   localparam int XLEN     = 64;
   localparam int INST_LEN = 32;

   typedef enum logic [2:0] {
      ITYPE_STD  = 3'd0,
      ITYPE_EXC  = 3'd1,
      ITYPE_INT  = 3'd2,
      ITYPE_ERET = 3'd3,
      ITYPE_NTB  = 3'd4,
      ITYPE_TB   = 3'd5,
      ITYPE_UIJ  = 3'd6
   } itype_e;

   typedef struct packed {
      itype_e              itype;
      logic [INST_LEN-1:0] iaddr;
      logic [31:0]         iretire;
      logic                ilastsize;
   } uop_entry_s;

   localparam logic [31:0] MASK_BRANCH    = 32'h0000_707f;
   localparam logic [31:0] MATCH_BEQ      = 32'h0000_0063;
   localparam logic [31:0] MATCH_BNE      = 32'h0000_1063;
   localparam logic [31:0] MATCH_P_BEQIMM = 32'h0000_2063;
   localparam logic [31:0] MATCH_P_BNEIMM = 32'h0000_3063;
   localparam logic [31:0] MATCH_BLT      = 32'h0000_4063;
   localparam logic [31:0] MATCH_BGE      = 32'h0000_5063;
   localparam logic [31:0] MATCH_BLTU     = 32'h0000_6063;
   localparam logic [31:0] MATCH_BGEU     = 32'h0000_7063;
   localparam logic [31:0] MASK_JALR      = 32'h0000_707f;
   localparam logic [31:0] MATCH_JALR     = 32'h0000_0067;
   localparam logic [31:0] MATCH_MRET     = 32'h3020_0073;
   localparam logic [31:0] MATCH_SRET     = 32'h1020_0073;
   localparam logic [31:0] MATCH_URET     = 32'h0020_0073;
   localparam logic [15:0] MASK_C_BRANCH  = 16'he003;
   localparam logic [15:0] MATCH_C_BEQZ   = 16'hc001;
   localparam logic [15:0] MATCH_C_BNEZ   = 16'he001;
   localparam logic [15:0] MASK_C_JUMP    = 16'hf07f;
   localparam logic [15:0] MATCH_C_JR     = 16'h8002;
   localparam logic [15:0] MATCH_C_JALR   = 16'h9002;
endpackage

module mure_uop_builder
   import mure_pkg::*;
#(
   parameter logic [31:0] ACC_MAX = 32'hFFFF_FFFF
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [XLEN-1:0]     iaddr_i,
   input  logic [INST_LEN-1:0] inst_i,
   input  logic                compressed_i,
   input  logic                branch_taken_i,
   input  logic                exception_i,
   input  logic                interrupt_i,
   output logic                uop_valid_o,
   input  logic                uop_ready_i,
   output uop_entry_s          uop_entry_o
);

   function automatic logic hit32(input logic [31:0] w, input logic [31:0] mask,
                                  input logic [31:0] match);
      return (w & mask) == match;
   endfunction

   logic                is_c;
   logic                is_eret, is_branch, is_uij, c_branch, c_jump;
   logic [1:0]          sz;
   logic                size_bit;
   logic [31:0]         acc, acc_new;
   logic [INST_LEN-1:0] blk_addr;
   logic                last_sz, blk_open;
   itype_e              itype;
   logic                emit, accept;
   uop_entry_s          rec;

`ifdef MURE_COMPRESSED_EN
   function automatic logic hit16(input logic [15:0] w, input logic [15:0] mask,
                                  input logic [15:0] match);
      return (w & mask) == match;
   endfunction

   logic unused_bits;
   assign unused_bits = ^iaddr_i[XLEN-1:INST_LEN];
   assign is_c        = compressed_i;
   assign c_branch    = is_c && (hit16(inst_i[15:0], MASK_C_BRANCH, MATCH_C_BEQZ) ||
                                 hit16(inst_i[15:0], MASK_C_BRANCH, MATCH_C_BNEZ));
   assign c_jump      = is_c && (inst_i[11:7] != 5'd0) &&
                        (hit16(inst_i[15:0], MASK_C_JUMP, MATCH_C_JR) ||
                         hit16(inst_i[15:0], MASK_C_JUMP, MATCH_C_JALR));
`else
   // Without compressed support every instruction is treated as 32-bit.
   logic unused_bits;
   assign unused_bits = ^{iaddr_i[XLEN-1:INST_LEN], compressed_i};
   assign is_c        = 1'b0;
   assign c_branch    = 1'b0;
   assign c_jump      = 1'b0;
`endif

   assign is_eret   = !is_c && (inst_i == MATCH_MRET || inst_i == MATCH_SRET ||
                                inst_i == MATCH_URET);
   assign is_branch = c_branch || (!is_c && (
                         hit32(inst_i, MASK_BRANCH, MATCH_BEQ)      ||
                         hit32(inst_i, MASK_BRANCH, MATCH_BNE)      ||
                         hit32(inst_i, MASK_BRANCH, MATCH_BLT)      ||
                         hit32(inst_i, MASK_BRANCH, MATCH_BGE)      ||
                         hit32(inst_i, MASK_BRANCH, MATCH_BLTU)     ||
                         hit32(inst_i, MASK_BRANCH, MATCH_BGEU)     ||
                         hit32(inst_i, MASK_BRANCH, MATCH_P_BNEIMM) ||
                         hit32(inst_i, MASK_BRANCH, MATCH_P_BEQIMM)));
   assign is_uij    = c_jump || (!is_c && hit32(inst_i, MASK_JALR, MATCH_JALR));

   assign sz       = is_c ? 2'd1 : 2'd2;
   assign size_bit = !is_c;
   assign acc_new  = acc + {30'd0, sz};
   assign ready_o  = !uop_valid_o || uop_ready_i;
   assign accept   = valid_i && ready_o;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      itype = ITYPE_STD;
      if (interrupt_i)      itype = ITYPE_INT;
      else if (exception_i) itype = ITYPE_EXC;
      else if (is_eret)     itype = ITYPE_ERET;
      else if (is_branch)   itype = branch_taken_i ? ITYPE_TB : ITYPE_NTB;
      else if (is_uij)      itype = ITYPE_UIJ;

      rec           = '0;
      rec.itype     = itype;
      rec.iaddr     = blk_open ? blk_addr : iaddr_i[INST_LEN-1:0];
      rec.iretire   = acc_new;
      rec.ilastsize = size_bit;
      emit          = 1'b1;
      case (itype)
         ITYPE_STD: emit = acc_new > (ACC_MAX - 32'd2);
         // A trapping instruction does not retire, so the record reflects the block so far.
         ITYPE_EXC, ITYPE_INT: begin
            rec.iretire   = acc;
            rec.ilastsize = blk_open ? last_sz : 1'b0;
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc         <= '0;
         blk_addr    <= '0;
         last_sz     <= 1'b0;
         blk_open    <= 1'b0;
         uop_valid_o <= 1'b0;
         uop_entry_o <= '0;
      end else begin
         if (accept) begin
            if (itype == ITYPE_STD && !emit) begin
               if (!blk_open) blk_addr <= iaddr_i[INST_LEN-1:0];
               acc      <= acc_new;
               last_sz  <= size_bit;
               blk_open <= 1'b1;
            end else begin
               acc      <= '0;
               blk_open <= 1'b0;
            end
         end
         if (accept && emit) begin
            uop_entry_o <= rec;
            uop_valid_o <= 1'b1;
         end else if (uop_ready_i) begin
            uop_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mure_uop_builder.sv
// Directed table-driven bench for mure_uop_builder plus backpressure, reset and ACC_MAX sequences.
`timescale 1ns/1ps

module tb_mure_uop_builder;
   import mure_pkg::*;

   logic                clk_i = 1'b0;
   logic                rst_i;
   logic                valid_i, compressed_i, branch_taken_i, exception_i, interrupt_i;
   logic                uop_ready_i;
   logic [XLEN-1:0]     iaddr_i;
   logic [INST_LEN-1:0] inst_i;
   logic                ready_o, uop_valid_o;
   uop_entry_s          uop_entry_o;
   logic                ready6, uop_valid6;
   uop_entry_s          uop_entry6;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] BEQ   = 32'h0000_0063;
   localparam logic [31:0] BNE   = 32'h0000_1063;
   localparam logic [31:0] JALR  = 32'h0000_80E7;
   localparam logic [31:0] MRET  = 32'h3020_0073;
   localparam logic [31:0] BEQI  = 32'h0000_2063;
   localparam logic [31:0] CBNEZ = 32'h0000_E001;
   localparam logic [31:0] CJR0  = 32'h0000_8002;
   localparam logic [31:0] CRET  = 32'h0000_8082;

   always #5 clk_i = ~clk_i;

   mure_uop_builder dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .iaddr_i(iaddr_i), .inst_i(inst_i), .compressed_i(compressed_i),
      .branch_taken_i(branch_taken_i), .exception_i(exception_i), .interrupt_i(interrupt_i),
      .uop_valid_o(uop_valid_o), .uop_ready_i(uop_ready_i), .uop_entry_o(uop_entry_o)
   );

   mure_uop_builder #(.ACC_MAX(32'd6)) dut6 (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready6),
      .iaddr_i(iaddr_i), .inst_i(inst_i), .compressed_i(compressed_i),
      .branch_taken_i(branch_taken_i), .exception_i(exception_i), .interrupt_i(interrupt_i),
      .uop_valid_o(uop_valid6), .uop_ready_i(uop_ready_i), .uop_entry_o(uop_entry6)
   );

   typedef struct {
      string       name;
      logic        v;
      logic [31:0] addr;
      logic [31:0] inst;
      logic        c, taken, exc, intr;
      logic        exp_v;
      uop_entry_s  exp_e;
   } vec_t;

   vec_t vecs[$];

   function automatic uop_entry_s mk(input itype_e t, input logic [31:0] a,
                                     input logic [31:0] r, input logic l);
      uop_entry_s e;
      e.itype = t; e.iaddr = a; e.iretire = r; e.ilastsize = l;
      return e;
   endfunction

   function automatic vec_t row(input string n, input logic v, input logic [31:0] a,
                                input logic [31:0] ins, input logic c, input logic t,
                                input logic e, input logic i, input logic ev,
                                input uop_entry_s ee);
      vec_t r;
      r.name = n; r.v = v; r.addr = a; r.inst = ins; r.c = c; r.taken = t;
      r.exc = e; r.intr = i; r.exp_v = ev; r.exp_e = ee;
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] ins,
                        input logic c, input logic t, input logic e, input logic i);
      valid_i = v; iaddr_i = {{(XLEN-32){1'b0}}, a}; inst_i = ins;
      compressed_i = c; branch_taken_i = t; exception_i = e; interrupt_i = i;
   endtask

   task automatic check_rec(input string name, input logic ev, input uop_entry_s ee);
      check({name, ".valid"}, 128'(uop_valid_o), 128'(ev));
      if (ev) check({name, ".entry"}, 128'(uop_entry_o), 128'(ee));
   endtask

   initial begin
      uop_entry_s held;
      rst_i = 1'b1; uop_ready_i = 1'b1;
      drive(1'b0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 1'b0);

      vecs.push_back(row("std_100", 1, 32'h100, NOP, 0, 0, 0, 0, 0, '0));
      vecs.push_back(row("std_104", 1, 32'h104, NOP, 0, 0, 0, 0, 0, '0));
      vecs.push_back(row("std_108", 1, 32'h108, NOP, 0, 0, 0, 0, 0, '0));
      vecs.push_back(row("beq_10c", 1, 32'h10C, BEQ, 0, 1, 0, 0, 1, mk(ITYPE_TB, 32'h100, 8, 1)));
`ifdef MURE_COMPRESSED_EN
      vecs.push_back(row("cbnez_200", 1, 32'h200, CBNEZ, 1, 0, 0, 0, 1, mk(ITYPE_NTB, 32'h200, 1, 0)));
      vecs.push_back(row("beq_202", 1, 32'h202, BEQ, 0, 0, 0, 0, 1, mk(ITYPE_NTB, 32'h202, 2, 1)));
`else
      vecs.push_back(row("cbnez_200", 1, 32'h200, CBNEZ, 1, 0, 0, 0, 0, '0));
      vecs.push_back(row("beq_204", 1, 32'h204, BEQ, 0, 0, 0, 0, 1, mk(ITYPE_NTB, 32'h200, 4, 1)));
`endif
      vecs.push_back(row("std_300", 1, 32'h300, NOP, 0, 0, 0, 0, 0, '0));
      vecs.push_back(row("std_304", 1, 32'h304, NOP, 0, 0, 0, 0, 0, '0));
      vecs.push_back(row("exc_308", 1, 32'h308, NOP, 0, 0, 1, 0, 1, mk(ITYPE_EXC, 32'h300, 4, 1)));
      vecs.push_back(row("int_exc_30c", 1, 32'h30C, NOP, 0, 0, 1, 1, 1, mk(ITYPE_INT, 32'h30C, 0, 0)));
      vecs.push_back(row("cstd_310", 1, 32'h310, NOP, 1, 0, 0, 0, 0, '0));
`ifdef MURE_COMPRESSED_EN
      vecs.push_back(row("int_312", 1, 32'h312, NOP, 0, 0, 0, 1, 1, mk(ITYPE_INT, 32'h310, 1, 0)));
`else
      vecs.push_back(row("int_312", 1, 32'h312, NOP, 0, 0, 0, 1, 1, mk(ITYPE_INT, 32'h310, 2, 1)));
`endif
      vecs.push_back(row("mret_320", 1, 32'h320, MRET, 0, 0, 0, 0, 1, mk(ITYPE_ERET, 32'h320, 2, 1)));
      vecs.push_back(row("cjr_x0_330", 1, 32'h330, CJR0, 1, 0, 0, 0, 0, '0));
`ifdef MURE_COMPRESSED_EN
      vecs.push_back(row("cret_332", 1, 32'h332, CRET, 1, 0, 0, 0, 1, mk(ITYPE_UIJ, 32'h330, 2, 0)));
      vecs.push_back(row("jalr_334", 1, 32'h334, JALR, 0, 0, 0, 0, 1, mk(ITYPE_UIJ, 32'h334, 2, 1)));
`else
      vecs.push_back(row("cret_332", 1, 32'h332, CRET, 1, 0, 0, 0, 0, '0));
      vecs.push_back(row("jalr_334", 1, 32'h334, JALR, 0, 0, 0, 0, 1, mk(ITYPE_UIJ, 32'h330, 6, 1)));
`endif
      vecs.push_back(row("beqimm_340", 1, 32'h340, BEQI, 0, 1, 0, 0, 1, mk(ITYPE_TB, 32'h340, 2, 1)));
      vecs.push_back(row("idle", 0, 32'h344, BEQ, 0, 1, 0, 0, 0, '0));

      // Reset values, observed while reset is held.
      repeat (2) @(negedge clk_i);
      check("rst.valid", 128'(uop_valid_o), 128'(1'b0));
      check("rst.entry", 128'(uop_entry_o), 128'(0));
      check("rst.ready", 128'(ready_o), 128'(1'b1));
      rst_i = 1'b0;

      foreach (vecs[k]) begin
         drive(vecs[k].v, vecs[k].addr, vecs[k].inst, vecs[k].c, vecs[k].taken,
               vecs[k].exc, vecs[k].intr);
         @(negedge clk_i);
         check_rec(vecs[k].name, vecs[k].exp_v, vecs[k].exp_e);
         check({vecs[k].name, ".ready"}, 128'(ready_o), 128'(1'b1));
      end

      // Backpressure: pending JALR record holds off the following MRET.
      uop_ready_i = 1'b0;
      drive(1'b1, 32'h500, JALR, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);
      held = mk(ITYPE_UIJ, 32'h500, 2, 1);
      check_rec("bp_jalr", 1'b1, held);
      drive(1'b1, 32'h504, MRET, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         check("bp_hold.ready", 128'(ready_o), 128'(1'b0));
         check_rec("bp_hold", 1'b1, held);
         @(negedge clk_i);
      end
      uop_ready_i = 1'b1;
      #1 check("bp_release.ready", 128'(ready_o), 128'(1'b1));
      @(negedge clk_i);
      check_rec("bp_mret", 1'b1, mk(ITYPE_ERET, 32'h504, 2, 1));

      // Asynchronous reset with a record still pending.
      drive(1'b0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
      uop_ready_i = 1'b0;
      #2 rst_i = 1'b1;
      #1 check("arst.valid", 128'(uop_valid_o), 128'(1'b0));
      check("arst.entry", 128'(uop_entry_o), 128'(0));
      check("arst.ready", 128'(ready_o), 128'(1'b1));
      @(negedge clk_i);
      rst_i = 1'b0; uop_ready_i = 1'b1;

      // Reset mid-block with acc=4: the open block must be lost.
      drive(1'b1, 32'h600, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);
      drive(1'b1, 32'h604, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);
      drive(1'b0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 rst_i = 1'b1;
      #1 check("mid_rst.valid", 128'(uop_valid_o), 128'(1'b0));
      @(negedge clk_i);
      rst_i = 1'b0;
      drive(1'b1, 32'h500, BNE, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);
      check_rec("post_rst_bne", 1'b1, mk(ITYPE_NTB, 32'h500, 2, 1));

      // ACC_MAX=6 instance: saturation on the third STD, new block at 0x40C.
      rst_i = 1'b1;
      drive(1'b0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'h400 + 32'(4 * k), NOP, 1'b0, 1'b0, 1'b0, 1'b0);
         @(negedge clk_i);
         check("acc6.valid", 128'(uop_valid6), 128'(k == 2));
         if (k == 2) check("acc6.entry", 128'(uop_entry6), 128'(mk(ITYPE_STD, 32'h400, 6, 1)));
      end
      drive(1'b1, 32'h410, BEQ, 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk_i);
      check("acc6_beq.valid", 128'(uop_valid6), 128'(1'b1));
      check("acc6_beq.entry", 128'(uop_entry6), 128'(mk(ITYPE_TB, 32'h40C, 4, 1)));
      drive(1'b0, 32'h0, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
